// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// pipe_pkg : shared encodings for the pipeline hazard/stall controller.
// Rev 1.0
// ============================================================================
package pipe_pkg;

  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DEAD = 2'd2;

  localparam logic [1:0] WB_NOP   = 2'b00;
  localparam logic [4:0] REG_ZERO = 5'd0;

  // A load in EX hazards the ID instruction when it writes a real register it reads.
  function automatic logic load_use_hit(input logic       memread,
                                        input logic [4:0] ld_rt,
                                        input logic [4:0] rs,
                                        input logic [4:0] rt);
    return memread & (ld_rt != REG_ZERO) & ((ld_rt == rs) | (ld_rt == rt));
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// pipe_hazard_if : hazard inputs from the pipeline and stage controls back to it.
// Optional stall counter port present only with PIPE_STALL_CNT_EN. Rev 1.0
// ============================================================================
interface pipe_hazard_if
`ifdef PIPE_STALL_CNT_EN
  #(parameter int CNT_W = 32)
`endif
  ();

  logic       idex_memread_i;
  logic [4:0] idex_rt_i;
  logic [4:0] ifid_rs_i;
  logic [4:0] ifid_rt_i;
  logic       branch_taken_i;
  logic       exmem_memreq_i;
  logic       dmem_ready_i;
  logic       pc_write_o;
  logic       ifid_write_o;
  logic       ifid_flush_o;
  logic       idex_write_o;
  logic       idex_flush_o;
  logic       exmem_write_o;
  logic       memwb_bubble_o;
  logic       dmem_timeout_o;
`ifdef PIPE_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cycles_o;
`endif

  modport master (
    output idex_memread_i, idex_rt_i, ifid_rs_i, ifid_rt_i, branch_taken_i,
           exmem_memreq_i, dmem_ready_i,
    input  pc_write_o, ifid_write_o, ifid_flush_o, idex_write_o, idex_flush_o,
           exmem_write_o, memwb_bubble_o, dmem_timeout_o
`ifdef PIPE_STALL_CNT_EN
    , input stall_cycles_o
`endif
  );

  modport slave (
    input  idex_memread_i, idex_rt_i, ifid_rs_i, ifid_rt_i, branch_taken_i,
           exmem_memreq_i, dmem_ready_i,
    output pc_write_o, ifid_write_o, ifid_flush_o, idex_write_o, idex_flush_o,
           exmem_write_o, memwb_bubble_o, dmem_timeout_o
`ifdef PIPE_STALL_CNT_EN
    , output stall_cycles_o
`endif
  );

endinterface
`default_nettype wire

// File: rtl/pipe_wait_timer.sv
`default_nettype none
// ============================================================================
// pipe_wait_timer : counts consecutive dmem wait cycles and flags the timeout.
// Rev 1.0
// ============================================================================
module pipe_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  wire logic clk_i,
  input  wire logic rst_n_i,
  input  wire logic start_i,
  input  wire logic waiting_i,
  input  wire logic ready_i,
  output logic      timeout_o
);

  localparam int W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [W-1:0] LAST = W'(MEM_TIMEOUT - 1);

  logic [W-1:0] wcnt_q, wcnt_d;

  always_comb begin
    wcnt_d    = wcnt_q;
    timeout_o = waiting_i & ~ready_i & (wcnt_q == LAST);
    if (start_i) begin
      wcnt_d = W'(1);
    end else if (waiting_i) begin
      if (ready_i)         wcnt_d = '0;
      else if (!timeout_o) wcnt_d = wcnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) wcnt_q <= '0;
    else          wcnt_q <= wcnt_d;
  end

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// pipe_hazard_ctrl : stall/flush sequencer for the 5-stage pipeline.
// Optional stall-cycle counter enabled by `PIPE_STALL_CNT_EN. Rev 1.0
// ============================================================================
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
`ifdef PIPE_STALL_CNT_EN
  , parameter int CNT_W = 32
`endif
) (
  input  wire logic   clk_i,
  input  wire logic   rst_n_i,
  pipe_hazard_if.slave hz
);

  logic [1:0] state_q, state_d;
  logic       mem_stall;
  logic       load_use;
  logic       timeout_hit;

  pipe_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .start_i   ((state_q == ST_RUN) & mem_stall),
    .waiting_i (state_q == ST_WAIT),
    .ready_i   (hz.dmem_ready_i),
    .timeout_o (timeout_hit)
  );

  always_comb begin
    mem_stall = hz.exmem_memreq_i & ~hz.dmem_ready_i & (state_q != ST_DEAD);
    load_use  = load_use_hit(hz.idex_memread_i, hz.idex_rt_i, hz.ifid_rs_i, hz.ifid_rt_i);

    state_d = state_q;
    case (state_q)
      ST_RUN:  if (mem_stall) state_d = ST_WAIT;
      ST_WAIT: if (hz.dmem_ready_i) state_d = ST_RUN;
               else if (timeout_hit) state_d = ST_DEAD;
      ST_DEAD: state_d = ST_DEAD;
      default: state_d = ST_RUN;
    endcase

    hz.pc_write_o     = 1'b1;
    hz.ifid_write_o   = 1'b1;
    hz.ifid_flush_o   = 1'b0;
    hz.idex_write_o   = 1'b1;
    hz.idex_flush_o   = 1'b0;
    hz.exmem_write_o  = 1'b1;
    hz.memwb_bubble_o = 1'b0;
    hz.dmem_timeout_o = (state_q == ST_DEAD);

    // MEM/WB keeps clocking while frozen; the bubble stops a repeated writeback.
    if ((state_q == ST_DEAD) || mem_stall) begin
      hz.pc_write_o     = 1'b0;
      hz.ifid_write_o   = 1'b0;
      hz.idex_write_o   = 1'b0;
      hz.exmem_write_o  = 1'b0;
      hz.memwb_bubble_o = 1'b1;
    end else if (load_use) begin
      hz.pc_write_o   = 1'b0;
      hz.ifid_write_o = 1'b0;
      hz.idex_flush_o = 1'b1;
    end else if (hz.branch_taken_i) begin
      hz.ifid_flush_o = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= ST_RUN;
    else          state_q <= state_d;
  end

`ifdef PIPE_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!hz.pc_write_o && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) stall_cnt_q <= '0;
    else          stall_cnt_q <= stall_cnt_d;
  end

  assign hz.stall_cycles_o = stall_cnt_q;
`endif

endmodule
`default_nettype wire
